// File: rtl/da_conv_sequencer.sv
// Bit-serial 3x3 convolution controller driving an external 9-input DA ROM.
// Presents one pixel bit-plane per cycle (LSB first) and shift-accumulates the signed ROM output.

module da_conv_lane #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] pix,
    output logic         bit0
);
    logic [W-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset)      sr <= '0;
        else if (load)  sr <= pix;
        else if (shift) sr <= sr >> 1;
    end

    assign bit0 = sr[0];
endmodule

module da_conv_sequencer #(
    parameter int PIXEL_WIDTH  = 8,
    parameter int ROM_WIDTH    = 8,
    parameter int RESULT_WIDTH = ROM_WIDTH + PIXEL_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [9*PIXEL_WIDTH-1:0]  in_pixels,
    output logic [8:0]                rom_addr,
    input  logic [ROM_WIDTH-1:0]      rom_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RESULT_WIDTH-1:0]   out_result,
    output logic                      busy
);
    localparam int KW = (PIXEL_WIDTH > 1) ? $clog2(PIXEL_WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(PIXEL_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                              state;
    logic [KW-1:0]                       k;
    logic signed [RESULT_WIDTH-1:0]      acc;
    logic [8:0][PIXEL_WIDTH-1:0]         pix;
    logic [8:0]                          plane;
    logic                                load;
    logic signed [ROM_WIDTH-1:0]         rd_s;
    logic signed [RESULT_WIDTH-1:0]      rd_ext;
    logic signed [RESULT_WIDTH-1:0]      sum;

    assign pix  = in_pixels;
    assign load = in_valid && in_ready;

    genvar i;
    generate
        for (i = 0; i < 9; i++) begin : g_lane
            da_conv_lane #(.W(PIXEL_WIDTH)) u_lane (
                .clk   (clk),
                .reset (reset),
                .load  (load),
                .shift (state == RUN),
                .pix   (pix[i]),
                .bit0  (plane[i])
            );
        end
    endgenerate

    // ROM is combinational, so the address must reflect the current plane in the same cycle.
    assign rom_addr = (state == RUN) ? plane : 9'd0;

    assign rd_s   = rom_data;
    assign rd_ext = RESULT_WIDTH'(rd_s);
    assign sum    = acc + (rd_ext << k);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            acc        <= '0;
            k          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        acc      <= '0;
                        k        <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= sum;
                    k   <= k + 1'b1;
                    if (k == K_LAST) begin
                        out_result <= sum;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_da_conv_sequencer.sv
// Directed and random checks of da_conv_sequencer against a behavioural da_rom_9 and sum-of-products model.

module tb_da_conv_sequencer;
    localparam int PW = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_pixels;
    logic [8:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        busy;
    logic [35:0] coef;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    da_conv_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixels  (in_pixels),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    // da_rom_9: sum of the signed 4-bit coefficients whose address bit is set
    always_comb begin
        int s;
        s = 0;
        for (int i = 0; i < 9; i++)
            if (rom_addr[i]) s += int'($signed(coef[4*i +: 4]));
        rom_data = 8'(s);
    end

    function automatic logic [15:0] ref_conv(input logic [35:0] c, input logic [71:0] p);
        int s;
        s = 0;
        for (int i = 0; i < 9; i++)
            s += int'($signed(c[4*i +: 4])) * int'(p[8*i +: 8]);
        return 16'(s);
    endfunction

    function automatic logic [8:0] plane_of(input logic [71:0] p, input int k);
        logic [8:0] a;
        for (int i = 0; i < 9; i++) a[i] = p[8*i + k];
        return a;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at the negedge where out_valid is first seen.
    task automatic run_window(input logic [35:0] c, input logic [71:0] p, input logic chk_addr,
                              output logic [15:0] res, output int lat);
        int   guard;
        logic addr_ok;
        coef      = c;
        in_pixels = p;
        in_valid  = 1'b1;
        guard     = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        addr_ok  = 1'b1;
        while (!out_valid && lat < 40) begin
            if (chk_addr && lat <= PW && rom_addr !== plane_of(p, lat - 1)) addr_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        res = out_result;
        if (chk_addr) check("rom_addr_planes", 32'(addr_ok), 32'd1);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [35:0] c;
        logic [71:0] p;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [15:0] res;
        int          lat;
        logic        ok;
        logic [15:0] held;
        int          acc_cyc[2];
        logic [15:0] r[2];
        int          na, nr, cyc;
        logic [35:0] rc;
        logic [71:0] rp;

        vecs[0] = '{36'h000010000, 72'h00_00_00_00_C8_00_00_00_00, 16'd200,   "identity_200"};
        vecs[1] = '{36'hFFFFFFFFF, {9{8'hFF}},                      16'hF709,  "all_neg_255"};
        vecs[2] = '{36'h111111111, 72'h09_08_07_06_05_04_03_02_01, 16'd45,    "ones_ramp"};
        vecs[3] = '{36'h777777777, {9{8'hFF}},                      16'h3EC1,  "max_pos"};
        vecs[4] = '{36'h888888888, {9{8'hFF}},                      16'hB848,  "max_neg"};
        vecs[5] = '{36'h20000000F, 72'h64_00_00_00_00_00_00_00_0A, 16'd190,   "corner_taps"};
        vecs[6] = '{36'h000010000, 72'h0,                           16'd0,     "zero_window"};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pixels = '0;
        coef      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready",   32'(in_ready),   32'd1);
        check("rst_out_valid",  32'(out_valid),  32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
        check("rst_rom_addr",   32'(rom_addr),   32'd0);
        check("rst_busy",       32'(busy),       32'd0);

        foreach (vecs[v]) begin
            run_window(vecs[v].c, vecs[v].p, v == 0, res, lat);
            check({vecs[v].name, "_result"},  32'(res), 32'(vecs[v].exp));
            check({vecs[v].name, "_latency"}, 32'(lat), 32'(PW + 1));
            take_result();
            check({vecs[v].name, "_in_ready_after"}, 32'(in_ready), 32'd1);
        end

        // Backpressure: result and flags held while out_ready stays low
        run_window(36'h111111111, 72'h09_08_07_06_05_04_03_02_01, 1'b0, res, lat);
        held = out_result;
        ok   = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        check("bp_hold_stable", 32'(ok),  32'd1);
        check("bp_result",      32'(res), 32'd45);
        take_result();
        check("bp_in_ready",  32'(in_ready),   32'd1);
        check("bp_out_valid", 32'(out_valid),  32'd0);
        check("bp_result_kept", 32'(out_result), 32'd45);

        // Back-to-back with in_valid held high and out_ready tied high
        coef      = 36'h111111111;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pixels = 72'h09_08_07_06_05_04_03_02_01;
        na = 0; nr = 0; cyc = 0;
        while ((na < 2 || nr < 2) && cyc < 60) begin
            if (in_ready && in_valid && na < 2) begin
                acc_cyc[na] = cyc;
                na++;
            end
            if (out_valid && nr < 2) begin
                r[nr] = out_result;
                nr++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (na == 1) in_pixels = {9{8'hFF}};
            if (na == 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("b2b_accepts", 32'(na), 32'd2);
        check("b2b_results", 32'(nr), 32'd2);
        if (na == 2) check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(PW + 2));
        if (nr == 2) begin
            check("b2b_result_a", 32'(r[0]), 32'd45);
            check("b2b_result_b", 32'(r[1]), 32'h08F7);
        end
        repeat (2) @(negedge clk);

        // Reset during RUN at k=3
        coef      = 36'h000010000;
        in_pixels = 72'h00_00_00_00_FF_00_00_00_00;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("mid_in_ready",  32'(in_ready),  32'd1);
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_rom_addr",  32'(rom_addr),  32'd0);
        check("mid_busy",      32'(busy),      32'd0);
        ok = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) ok = 1'b0;
        end
        check("mid_no_result", 32'(ok), 32'd1);
        run_window(36'h000010000, 72'h00_00_00_00_4D_00_00_00_00, 1'b1, res, lat);
        check("mid_next_result", 32'(res), 32'd77);
        take_result();

        // Random windows against random coefficients
        for (int t = 0; t < 1000; t++) begin
            rc = {4'($urandom), 32'($urandom)};
            rp = {8'($urandom), 32'($urandom), 32'($urandom)};
            run_window(rc, rp, 1'b0, res, lat);
            check("random_result", 32'(res), 32'(ref_conv(rc, rp)));
            take_result();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
